// File: rtl/weighted_pulse_seq.sv
// Switch-weighted pulse sequencer: a start latches the switch word, sums per-switch
// weights into a saturated duration and holds the output high for that many ticks.
module weighted_pulse_seq #(
  parameter int                         N_SW      = 4,
  parameter int                         WEIGHT_W  = 8,
  parameter int                         CNT_W     = 10,
  parameter logic [N_SW*WEIGHT_W-1:0]   WEIGHTS   = {8'd54, 8'd87, 8'd120, 8'd131},
  parameter int                         GAP_TICKS = 16
) (
  input  logic             i_sysclk,
  input  logic             i_rst,
  input  logic             i_tick,
  input  logic [N_SW-1:0]  i_sw,
  input  logic             i_write_pulse,
  input  logic             i_auto_toggle,
  output logic [N_SW-1:0]  o_sw_latch,
  output logic [CNT_W-1:0] o_total,
  output logic             o_auto_active,
  output logic             o_out,
  output logic             o_busy,
  output logic             o_out_trig
);

  localparam int               SUM_W    = CNT_W + WEIGHT_W;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_TICKS);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_out;
  logic              r_auto;
  logic              r_busy;
  logic              r_outTrig;
  logic [N_SW-1:0]   r_swLatch;
  logic [CNT_W-1:0]  r_total;

  state_t            w_stateNext;
  logic [CNT_W-1:0]  w_cntNext;
  logic              w_outNext;
  logic              w_autoNext;
  logic [N_SW-1:0]   w_swLatchNext;
  logic [CNT_W-1:0]  w_totalNext;
  logic [SUM_W-1:0]  w_sum;
  logic [CNT_W-1:0]  w_total;
  logic              w_valid;

  // Duration is taken from the live switches; only used on the start cycle.
  always_comb begin
    w_sum = '0;
    for (int i = 0; i < N_SW; i++) begin
      if (i_sw[i]) begin
        w_sum = w_sum + SUM_W'(WEIGHTS[i*WEIGHT_W +: WEIGHT_W]);
      end
    end
    w_total = (w_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : w_sum[CNT_W-1:0];
    w_valid = (w_total != '0);
  end

  always_comb begin
    w_stateNext   = r_state;
    w_cntNext     = r_cnt;
    w_outNext     = r_out;
    w_autoNext    = r_auto;
    w_swLatchNext = r_swLatch;
    w_totalNext   = r_total;

    case (r_state)
      ST_IDLE: begin
        if ((i_auto_toggle || i_write_pulse) && w_valid) begin
          w_stateNext   = ST_PULSE;
          w_cntNext     = w_total;
          w_outNext     = 1'b1;
          w_swLatchNext = i_sw;
          w_totalNext   = w_total;
          w_autoNext    = i_auto_toggle;
        end
      end

      ST_PULSE: begin
        if (i_auto_toggle && r_auto) begin
          w_stateNext = ST_IDLE;
          w_cntNext   = '0;
          w_outNext   = 1'b0;
          w_autoNext  = 1'b0;
        end else if (i_tick) begin
          if (r_cnt == CNT_ONE) begin
            w_outNext = 1'b0;
            if (r_auto) begin
              w_stateNext = ST_GAP;
              w_cntNext   = GAP_LOAD;
            end else begin
              w_stateNext = ST_IDLE;
              w_cntNext   = '0;
            end
          end else begin
            w_cntNext = r_cnt - CNT_ONE;
          end
        end
      end

      // The repeat pulse reuses the latched total; the switches are not looked at again.
      ST_GAP: begin
        if (i_auto_toggle && r_auto) begin
          w_stateNext = ST_IDLE;
          w_cntNext   = '0;
          w_outNext   = 1'b0;
          w_autoNext  = 1'b0;
        end else if (i_tick) begin
          if (r_cnt == CNT_ONE) begin
            w_stateNext = ST_PULSE;
            w_cntNext   = r_total;
            w_outNext   = 1'b1;
          end else begin
            w_cntNext = r_cnt - CNT_ONE;
          end
        end
      end

      default: begin
        w_stateNext = ST_IDLE;
        w_cntNext   = '0;
        w_outNext   = 1'b0;
        w_autoNext  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_sysclk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_out     <= 1'b0;
      r_auto    <= 1'b0;
      r_busy    <= 1'b0;
      r_outTrig <= 1'b0;
      r_swLatch <= '0;
      r_total   <= '0;
    end else begin
      r_state   <= w_stateNext;
      r_cnt     <= w_cntNext;
      r_out     <= w_outNext;
      r_auto    <= w_autoNext;
      r_busy    <= (w_stateNext != ST_IDLE);
      r_outTrig <= r_auto | r_out;
      r_swLatch <= w_swLatchNext;
      r_total   <= w_totalNext;
    end
  end

  assign o_sw_latch    = r_swLatch;
  assign o_total       = r_total;
  assign o_auto_active = r_auto;
  assign o_out         = r_out;
  assign o_busy        = r_busy;
  assign o_out_trig    = r_outTrig;

endmodule

// File: tb/tb_weighted_pulse_seq.sv
// Randomized scoreboard bench for weighted_pulse_seq: the driver predicts each pulse
// from the weight-sum rules, and a negedge monitor measures pulses and gaps and compares them.
module tb_weighted_pulse_seq;

  localparam int GAP = 16;

  logic       i_sysclk = 1'b0;
  logic       i_rst;
  logic       i_tick;
  logic [3:0] i_sw;
  logic       i_write_pulse;
  logic       i_auto_toggle;
  logic [3:0] o_sw_latch;
  logic [9:0] o_total;
  logic       o_auto_active;
  logic       o_out;
  logic       o_busy;
  logic       o_out_trig;

  logic       s_tick;
  logic [3:0] s_sw;
  logic       s_wp;
  logic [3:0] so_sw_latch;
  logic [7:0] so_total;
  logic       so_auto_active;
  logic       so_out;
  logic       so_busy;
  logic       so_out_trig;

  always #5 i_sysclk = ~i_sysclk;

  weighted_pulse_seq #(.GAP_TICKS(GAP)) dut (
    .i_sysclk(i_sysclk), .i_rst(i_rst), .i_tick(i_tick), .i_sw(i_sw),
    .i_write_pulse(i_write_pulse), .i_auto_toggle(i_auto_toggle),
    .o_sw_latch(o_sw_latch), .o_total(o_total), .o_auto_active(o_auto_active),
    .o_out(o_out), .o_busy(o_busy), .o_out_trig(o_out_trig)
  );

  weighted_pulse_seq #(.CNT_W(8)) dutSat (
    .i_sysclk(i_sysclk), .i_rst(i_rst), .i_tick(s_tick), .i_sw(s_sw),
    .i_write_pulse(s_wp), .i_auto_toggle(1'b0),
    .o_sw_latch(so_sw_latch), .o_total(so_total), .o_auto_active(so_auto_active),
    .o_out(so_out), .o_busy(so_busy), .o_out_trig(so_out_trig)
  );

  typedef struct {
    int       len;
    int       gap;
    int       tot;
    logic [3:0] sw;
    logic     auto;
    logic     endBusy;
  } exp_t;

  exp_t sbq[$];
  int   nChecks = 0;
  int   nBad    = 0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    nChecks++;
    if (actual !== expected) begin
      nBad++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic int modelTotal(input logic [3:0] s, input int cntw);
    int w[4] = '{131, 120, 87, 54};
    int sum = 0;
    for (int i = 0; i < 4; i++) if (s[i]) sum += w[i];
    if (sum > (1 << cntw) - 1) sum = (1 << cntw) - 1;
    return sum;
  endfunction

  // Monitor: measures each pulse in ticks and the gap ticks that preceded it.
  logic prevOut  = 1'b0;
  logic prevTrig = 1'b0;
  int   hiCnt    = 0;
  int   gapCnt   = 0;

  always @(negedge i_sysclk) begin
    exp_t e;
    if (i_rst) begin
      prevOut  = 1'b0;
      prevTrig = 1'b0;
      hiCnt    = 0;
      gapCnt   = 0;
    end else begin
      checkOutput("out_trig", int'(o_out_trig), int'(prevTrig));
      prevTrig = o_auto_active | o_out;
      if (o_out && !prevOut) begin
        if (sbq.size() == 0) begin
          checkOutput("unexpected_pulse", 1, 0);
        end else begin
          checkOutput("gap_len", gapCnt, sbq[0].gap);
          checkOutput("auto_at_rise", int'(o_auto_active), int'(sbq[0].auto));
          checkOutput("busy_at_rise", int'(o_busy), 1);
        end
        hiCnt = 0;
      end
      if (!o_out && prevOut) begin
        if (sbq.size() == 0) begin
          checkOutput("unexpected_fall", 1, 0);
        end else begin
          e = sbq.pop_front();
          checkOutput("pulse_len", hiCnt, e.len);
          checkOutput("total", int'(o_total), e.tot);
          checkOutput("sw_latch", int'(o_sw_latch), int'(e.sw));
          checkOutput("busy_at_fall", int'(o_busy), int'(e.endBusy));
        end
        gapCnt = 0;
      end
      if (o_out && i_tick) hiCnt++;
      if (!o_out && o_busy && i_tick) gapCnt++;
      if (!o_busy) gapCnt = 0;
      prevOut = o_out;
    end
  end

  function automatic logic randTick();
    return ($urandom_range(0, 3) != 0);
  endfunction

  task automatic applyStimulus(input logic wp, input logic at, input logic [3:0] swv, input logic tk);
    i_write_pulse = wp;
    i_auto_toggle = at;
    i_sw          = swv;
    i_tick        = tk;
    @(posedge i_sysclk);
    #1;
    i_write_pulse = 1'b0;
    i_auto_toggle = 1'b0;
    i_tick        = 1'b0;
  endtask

  task automatic runOneShot(input logic [3:0] swv, input bit fastTick);
    int   tot;
    int   t;
    logic tk;
    tot = modelTotal(swv, 10);
    if (tot == 0) begin
      applyStimulus(1'b1, 1'b0, swv, randTick());
      checkOutput("ignored_busy", int'(o_busy), 0);
      checkOutput("ignored_out", int'(o_out), 0);
      return;
    end
    sbq.push_back('{len: tot, gap: 0, tot: tot, sw: swv, auto: 1'b0, endBusy: 1'b0});
    applyStimulus(1'b1, 1'b0, swv, randTick());
    t = 0;
    while (t < tot) begin
      tk = fastTick ? 1'b1 : randTick();
      applyStimulus($urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0, 4'($urandom), tk);
      if (tk) t++;
    end
    checkOutput("oneshot_end_busy", int'(o_busy), 0);
    checkOutput("oneshot_auto", int'(o_auto_active), 0);
    repeat (3) applyStimulus(1'b0, 1'b0, 4'($urandom), randTick());
  endtask

  // Auto run aborted after abortAt ticks; tick is held low on the abort cycle.
  task automatic runAuto(input logic [3:0] swv, input int abortAt, input bit withWp);
    int   tot;
    int   per;
    int   full;
    int   rem;
    int   nDone;
    int   t;
    logic tk;
    tot   = modelTotal(swv, 10);
    per   = tot + GAP;
    full  = abortAt / per;
    rem   = abortAt % per;
    nDone = full + ((rem >= tot) ? 1 : 0);
    for (int k = 0; k < nDone; k++)
      sbq.push_back('{len: tot, gap: (k == 0) ? 0 : GAP, tot: tot, sw: swv, auto: 1'b1, endBusy: 1'b1});
    if (rem < tot)
      sbq.push_back('{len: rem, gap: (full == 0) ? 0 : GAP, tot: tot, sw: swv, auto: 1'b1, endBusy: 1'b0});
    applyStimulus(withWp, 1'b1, swv, randTick());
    t = 0;
    while (t < abortAt) begin
      tk = randTick();
      applyStimulus($urandom_range(0, 7) == 0, 1'b0, 4'($urandom), tk);
      if (tk) t++;
    end
    applyStimulus(1'b0, 1'b1, 4'($urandom), 1'b0);
    checkOutput("abort_auto", int'(o_auto_active), 0);
    checkOutput("abort_out", int'(o_out), 0);
    checkOutput("abort_busy", int'(o_busy), 0);
    checkOutput("abort_total_kept", int'(o_total), tot);
    checkOutput("abort_sw_kept", int'(o_sw_latch), int'(swv));
    repeat (3) applyStimulus(1'b0, 1'b0, 4'($urandom), randTick());
  endtask

  initial begin
    logic [3:0] rs;
    int         cnt;
    int         tot;
    i_rst = 1'b1;
    i_tick = 1'b0; i_sw = '0; i_write_pulse = 1'b0; i_auto_toggle = 1'b0;
    s_tick = 1'b0; s_sw = '0; s_wp = 1'b0;
    repeat (3) @(posedge i_sysclk);
    #1;
    checkOutput("rst_out", int'(o_out), 0);
    checkOutput("rst_busy", int'(o_busy), 0);
    checkOutput("rst_auto", int'(o_auto_active), 0);
    checkOutput("rst_trig", int'(o_out_trig), 0);
    checkOutput("rst_total", int'(o_total), 0);
    checkOutput("rst_sw_latch", int'(o_sw_latch), 0);
    @(negedge i_sysclk);
    #1 i_rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b1);

    runOneShot(4'b0001, 1'b0);
    runOneShot(4'b0000, 1'b0);
    applyStimulus(1'b0, 1'b1, 4'b0000, 1'b1);
    checkOutput("auto_zero_busy", int'(o_busy), 0);
    checkOutput("auto_zero_auto", int'(o_auto_active), 0);

    runAuto(4'b0110, 3 * (207 + GAP) + 207 + 5, 1'b0);
    runAuto(4'b0110, 3 * (207 + GAP) + 100, 1'b1);

    // Asynchronous reset 50 ticks into a 131-tick pulse.
    sbq.push_back('{len: 131, gap: 0, tot: 131, sw: 4'b0001, auto: 1'b0, endBusy: 1'b0});
    applyStimulus(1'b1, 1'b0, 4'b0001, 1'b0);
    repeat (50) applyStimulus(1'b0, 1'b0, 4'($urandom), 1'b1);
    checkOutput("pre_reset_out", int'(o_out), 1);
    #2 i_rst = 1'b1;
    #1;
    checkOutput("async_rst_out", int'(o_out), 0);
    checkOutput("async_rst_busy", int'(o_busy), 0);
    checkOutput("async_rst_auto", int'(o_auto_active), 0);
    checkOutput("async_rst_trig", int'(o_out_trig), 0);
    checkOutput("async_rst_total", int'(o_total), 0);
    sbq.delete();
    @(posedge i_sysclk);
    @(negedge i_sysclk);
    #1 i_rst = 1'b0;
    runOneShot(4'b1000, 1'b1);

    // Saturation on the narrow-counter instance: 392 clips to 255.
    s_sw = 4'b1111;
    s_wp = 1'b1;
    @(posedge i_sysclk);
    #1 s_wp = 1'b0;
    checkOutput("sat_total", int'(so_total), modelTotal(4'b1111, 8));
    s_tick = 1'b1;
    s_sw   = 4'b0001;
    cnt = 0;
    for (int k = 0; k < 400 && so_out; k++) begin
      cnt++;
      @(posedge i_sysclk);
      #1;
    end
    s_tick = 1'b0;
    checkOutput("sat_pulse_len", cnt, 255);
    checkOutput("sat_busy_end", int'(so_busy), 0);

    for (int n = 0; n < 6; n++) begin
      rs = 4'($urandom);
      if ($urandom_range(0, 2) == 0 || rs == 4'b0000) begin
        runOneShot(rs, bit'($urandom_range(0, 1)));
      end else begin
        tot = modelTotal(rs, 10);
        runAuto(rs, $urandom_range(1, 2 * (tot + GAP) + tot), bit'($urandom_range(0, 1)));
      end
    end

    repeat (5) applyStimulus(1'b0, 1'b0, 4'h0, 1'b1);
    checkOutput("queue_empty", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", nChecks, nBad);
    $finish;
  end

endmodule

// File: doc/weighted_pulse_seq.md
Name: weighted_pulse_seq

Overview:
- Parametrised successor to the switch-weighted pulse holder.
- A start request latches an N-bit switch word and computes a duration as the sum of per-switch weights.
- Drives `out` high for exactly that many tick events.
- Auto mode re-fires the latched duration repeatedly, with a programmable gap, until toggled off. It sits between the debouncers / clock divider and the output trigger stage.

Parameters:
- N_SW, 4: number of switch inputs / channels.
- WEIGHT_W, 8: width of each weight entry.
- CNT_W, 10: width of duration/gap counters and `total`.
- WEIGHTS, {8'd54,8'd87,8'd120,8'd131}: packed N_SW*WEIGHT_W vector; entry i at bits [i*WEIGHT_W +: WEIGHT_W] is the weight of sw[i]. Default gives sw[0]=131, sw[1]=120, sw[2]=87, sw[3]=54.
- GAP_TICKS, 16: auto-mode low time in ticks between pulses; legal range 1..2^CNT_W-1.

Ports:
- sysclk, in, 1: system clock; all state on posedge.
- rst, in, 1: asynchronous, active-high reset.
- tick, in, 1: single-cycle timing enable from clockdiv; all counting happens only on cycles with tick=1.
- sw, in, N_SW: live switch word.
- write_pulse, in, 1: single-cycle one-shot start request (already debounced and edge-detected).
- auto_toggle, in, 1: single-cycle auto-mode toggle (already debounced and edge-detected).
- sw_latch, out, N_SW: switch word captured at start.
- total, out, CNT_W: computed duration of the current or last run.
- auto_active, out, 1: auto mode engaged.
- out, out, 1: timed pulse output.
- busy, out, 1: state is not IDLE.
- out_trig, out, 1: registered `auto_active | out`.

Behaviour:
- Reset (async, any time, including mid-pulse):
  - state=IDLE.
  - out, auto_active, out_trig, busy = 0.
  - sw_latch=0, total=0, internal counters=0.
- Duration rule:
  - Duration = sum of WEIGHTS[i] over set sw[i], computed in CNT_W+WEIGHT_W bits.
  - If the sum exceeds 2^CNT_W-1, it saturates to 2^CNT_W-1.
  - A computed total of 0 counts as an invalid start.
- States: IDLE, PULSE, GAP.
- IDLE:
  - auto_toggle=1 with valid total: sw_latch<=sw, total<=sum, auto_active<=1, go to PULSE.
  - Otherwise, write_pulse=1 with valid total: same latching with auto_active unchanged (0), go to PULSE.
  - auto_toggle and write_pulse in the same cycle: auto wins.
  - Start with sw=0 or zero total: ignored, no output change.
- PULSE:
  - out=1 from the cycle after entry.
  - Remaining counter loads `total` on entry and decrements on each tick.
  - On the tick where remaining==1: out<=0 in that edge. If auto_active, go to GAP; otherwise go to IDLE.
  - out is therefore high across exactly `total` tick events. The first counted tick is the first tick strictly after the entry cycle; a tick coincident with the start cycle is not counted.
- GAP:
  - out=0.
  - Counter loads GAP_TICKS on entry and decrements on tick.
  - On the tick where it reaches 1: go to PULSE, reloading the latched total. sw is not re-sampled.
- auto_toggle while auto_active=1 (in PULSE or GAP): abort.
  - Next edge: auto_active<=0, out<=0, state<=IDLE.
  - sw_latch and total are retained.
- auto_toggle in PULSE while auto_active=0: ignored.
- write_pulse outside IDLE: ignored; it never restarts or extends a pulse.
- Live sw changes after the start cycle have no effect.
- busy = (state != IDLE), registered with the state.
- out_trig is registered one cycle after auto_active/out.
- tick held high continuously is legal: the block counts every cycle.

Test Plan:
- Reset then write_pulse with sw=4'b0001 → total=131; out high for exactly 131 ticks; busy drops with out; auto_active stays 0.
- sw=4'b1111 with CNT_W=8 override → sum 392 saturates to total=255; out high 255 ticks.
- auto_toggle with sw=4'b0110, GAP_TICKS=16 → total=207; out pattern repeats 207 high / 16 low for ≥3 periods. Changing sw mid-run has no effect on the period.
- auto_toggle again mid-GAP and again mid-PULSE (separate runs) → next edge: out=0, auto_active=0, state IDLE; total still 207.
- write_pulse with sw=0, and write_pulse during an active pulse → no state change; the pulse length is unchanged.
- Assert rst 50 ticks into a 131-tick pulse, asynchronously between edges → out, busy, auto_active, out_trig immediately 0. After release, a write_pulse with sw=4'b1000 gives a 54-tick pulse.
